audio_mixer: RTL and testbench



---
 rtl/audio_pkg.sv | 33 +++
 rtl/audio_mixer_if.sv | 28 ++
 rtl/audio_sat.sv | 32 +++
 rtl/audio_mixer.sv | 126 ++++++++++++
 tb/tb_audio_mixer.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/audio_pkg.sv
// Shared definitions for the audio datapath: mixer FSM encoding, mixer sizing helpers and
// signed saturation bounds reused by downstream audio blocks.
package audio_pkg;

    // Mixer FSM encoding, kept as plain constants for compatibility with older tools.
    typedef logic [1:0] mix_state_t;
    localparam mix_state_t StIdle   = 2'd0;
    localparam mix_state_t StAccum  = 2'd1;
    localparam mix_state_t StFinish = 2'd2;

    // Accumulator width that holds CHANNELS full-scale vol*gain products without wrapping.
    function automatic int unsigned acc_width(input int unsigned ch, input int unsigned vb,
                                              input int unsigned gb);
        return vb + gb + $clog2(ch);
    endfunction

    // DC midpoint of the accumulated sum (half of full scale, truncated).
    function automatic int unsigned mix_mid(input int unsigned ch, input int unsigned vb,
                                            input int unsigned gb);
        return (ch * ((32'd1 << vb) - 32'd1) * ((32'd1 << gb) - 32'd1)) / 32'd2;
    endfunction

    // Largest value representable in a w-bit two's complement word.
    function automatic longint sat_max(input int unsigned w);
        return (longint'(1) << (w - 1)) - longint'(1);
    endfunction

    // Smallest value representable in a w-bit two's complement word.
    function automatic longint sat_min(input int unsigned w);
        return -(longint'(1) << (w - 1));
    endfunction

endpackage

// File: rtl/audio_mixer_if.sv
// Sample-side bus of the audio mixer: tick/volume/gain/mute in, mixed sample and status out.
interface audio_mixer_if #(
    parameter int unsigned WIDTH     = 12,
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned VOL_BITS  = 4,
    parameter int unsigned GAIN_BITS = 4
);
    logic                            tick;
    logic [CHANNELS*VOL_BITS-1:0]    chan_vol;
    logic [CHANNELS*GAIN_BITS-1:0]   chan_gain;
    logic                            mute;
    logic signed [WIDTH-1:0]         data;
    logic                            valid;
    logic                            busy;
    logic                            overrun;

    // Producer of ticks and channel settings; consumer of the mixed sample.
    modport master (
        output tick, chan_vol, chan_gain, mute,
        input  data, valid, busy, overrun
    );

    // The mixer itself.
    modport slave (
        input  tick, chan_vol, chan_gain, mute,
        output data, valid, busy, overrun
    );
endinterface

// File: rtl/audio_sat.sv
// Combinational signed saturator: clamps an IN_W-bit two's complement value into OUT_W bits.
module audio_sat
    import audio_pkg::*;
#(
    parameter int unsigned IN_W  = 13,
    parameter int unsigned OUT_W = 12
) (
    input  logic signed [IN_W-1:0]  i_din,
    output logic signed [OUT_W-1:0] o_dout
);
    localparam logic signed [OUT_W-1:0] MAX_V = OUT_W'(sat_max(OUT_W));
    localparam logic signed [OUT_W-1:0] MIN_V = OUT_W'(sat_min(OUT_W));

    if (IN_W > OUT_W) begin : g_clamp
        localparam int unsigned HW = IN_W - OUT_W + 1;
        logic [HW-1:0] w_top;

        // Bits that must all equal the sign bit for the value to fit in OUT_W.
        assign w_top = i_din[IN_W-1:OUT_W-1];

        // Pass through when in range, otherwise clamp toward the sign of the input.
        always_comb begin
            o_dout = i_din[OUT_W-1:0];
            if (w_top != {HW{1'b0}} && w_top != {HW{1'b1}}) begin
                o_dout = i_din[IN_W-1] ? MIN_V : MAX_V;
            end
        end
    end else begin : g_extend
        // Narrower or equal input always fits; sign-extend.
        assign o_dout = OUT_W'(i_din);
    end
endmodule

// File: rtl/audio_mixer.sv
// Sequential multiply-accumulate mixer: one channel per clock, DC removal, scaling and
// saturation to a signed WIDTH-bit sample held until the next mix.
module audio_mixer
    import audio_pkg::*;
#(
    parameter int unsigned WIDTH     = 12,
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned VOL_BITS  = 4,
    parameter int unsigned GAIN_BITS = 4,
    parameter int unsigned SHIFT     = 2
) (
    input logic         clk,
    input logic         reset_n,
    audio_mixer_if.slave bus
);
    localparam int unsigned AW  = acc_width(CHANNELS, VOL_BITS, GAIN_BITS);
    localparam int unsigned PW  = VOL_BITS + GAIN_BITS;
    // One extra bit so the DC-removed sum is signed without overflow.
    localparam int unsigned SW  = AW + 1;
    // Shift is done at full width so nothing wraps before saturation.
    localparam int unsigned TW  = SW + SHIFT;
    localparam int unsigned IW  = $clog2(CHANNELS);
    localparam int unsigned MID = mix_mid(CHANNELS, VOL_BITS, GAIN_BITS);
    localparam logic [IW-1:0] LAST_IDX = IW'(CHANNELS - 1);

    mix_state_t                     r_state;
    logic [CHANNELS*VOL_BITS-1:0]   r_vol;
    logic [CHANNELS*GAIN_BITS-1:0]  r_gain;
    logic                           r_mute;
    logic [AW-1:0]                  r_acc;
    logic [IW-1:0]                  r_idx;
    logic signed [WIDTH-1:0]        r_data;
    logic                           r_valid;
    logic                           r_busy;
    logic                           r_overrun;

    logic [VOL_BITS-1:0]            w_vol;
    logic [GAIN_BITS-1:0]           w_gain;
    logic [PW-1:0]                  w_prod;
    logic signed [SW-1:0]           w_s;
    logic signed [TW-1:0]           w_s_ext;
    logic signed [TW-1:0]           w_t;
    logic signed [WIDTH-1:0]        w_sat;

    // Select the snapshot volume and gain of the channel being accumulated.
    always_comb begin
        w_vol  = '0;
        w_gain = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            if (r_idx == IW'(i)) begin
                w_vol  = r_vol[i*VOL_BITS +: VOL_BITS];
                w_gain = r_gain[i*GAIN_BITS +: GAIN_BITS];
            end
        end
    end

    assign w_prod  = PW'(w_vol) * PW'(w_gain);
    assign w_s     = $signed({1'b0, r_acc}) - $signed(SW'(MID));
    assign w_s_ext = TW'(w_s);
    assign w_t     = w_s_ext <<< SHIFT;

    audio_sat #(
        .IN_W  (TW),
        .OUT_W (WIDTH)
    ) u_sat (
        .i_din  (w_t),
        .o_dout (w_sat)
    );

    // Mix FSM: snapshot on tick, accumulate one channel per edge, publish on the finish edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= StIdle;
            r_vol     <= '0;
            r_gain    <= '0;
            r_mute    <= 1'b0;
            r_acc     <= '0;
            r_idx     <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (bus.tick) begin
                        r_vol   <= bus.chan_vol;
                        r_gain  <= bus.chan_gain;
                        r_mute  <= bus.mute;
                        r_acc   <= '0;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= StAccum;
                    end
                end
                StAccum: begin
                    // A tick here is dropped; flag it and keep mixing.
                    r_overrun <= bus.tick;
                    r_acc     <= r_acc + AW'(w_prod);
                    r_idx     <= r_idx + 1'b1;
                    if (r_idx == LAST_IDX) begin
                        r_state <= StFinish;
                    end
                end
                StFinish: begin
                    r_overrun <= bus.tick;
                    r_data    <= r_mute ? '0 : w_sat;
                    r_valid   <= 1'b1;
                    r_busy    <= 1'b0;
                    r_state   <= StIdle;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign bus.data    = r_data;
    assign bus.valid   = r_valid;
    assign bus.busy    = r_busy;
    assign bus.overrun = r_overrun;
endmodule

// File: tb/tb_audio_mixer.sv
// Randomized self-checking bench for audio_mixer; a SHIFT=2 and a SHIFT=3 instance share
// stimulus and are compared against an arithmetic reference model.
module tb_audio_mixer;
    localparam int CH = 4;
    localparam int VB = 4;
    localparam int GB = 4;
    localparam int W  = 12;

    logic clk;
    logic reset_n;
    logic tb_tick;
    logic [CH*VB-1:0] tb_vol;
    logic [CH*GB-1:0] tb_gain;
    logic tb_mute;

    int n_checks;
    int n_fail;
    int last2;
    int last3;

    audio_mixer_if #(.WIDTH(W), .CHANNELS(CH), .VOL_BITS(VB), .GAIN_BITS(GB)) bus2 ();
    audio_mixer_if #(.WIDTH(W), .CHANNELS(CH), .VOL_BITS(VB), .GAIN_BITS(GB)) bus3 ();

    assign bus2.tick      = tb_tick;
    assign bus2.chan_vol  = tb_vol;
    assign bus2.chan_gain = tb_gain;
    assign bus2.mute      = tb_mute;
    assign bus3.tick      = tb_tick;
    assign bus3.chan_vol  = tb_vol;
    assign bus3.chan_gain = tb_gain;
    assign bus3.mute      = tb_mute;

    audio_mixer #(.WIDTH(W), .CHANNELS(CH), .VOL_BITS(VB), .GAIN_BITS(GB), .SHIFT(2)) u_dut2 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus2)
    );

    audio_mixer #(.WIDTH(W), .CHANNELS(CH), .VOL_BITS(VB), .GAIN_BITS(GB), .SHIFT(3)) u_dut3 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: sum of products, minus half full scale, times 2^sh, clamped to W bits.
    function automatic int model_mix(input logic [CH*VB-1:0] vol, input logic [CH*GB-1:0] gain,
                                     input logic m, input int sh);
        int acc;
        int mid;
        int t;
        if (m) return 0;
        acc = 0;
        for (int i = 0; i < CH; i++) begin
            acc += int'(vol[i*VB +: VB]) * int'(gain[i*GB +: GB]);
        end
        mid = CH * ((1 << VB) - 1) * ((1 << GB) - 1) / 2;
        t = (acc - mid) * (1 << sh);
        if (t > (1 << (W - 1)) - 1) t = (1 << (W - 1)) - 1;
        if (t < -(1 << (W - 1))) t = -(1 << (W - 1));
        return t;
    endfunction

    task automatic check_ctrl(input logic ev, input logic eb, input logic eo);
        check_val("valid2", 32'(bus2.valid), 32'(ev));
        check_val("valid3", 32'(bus3.valid), 32'(ev));
        check_val("busy2", 32'(bus2.busy), 32'(eb));
        check_val("busy3", 32'(bus3.busy), 32'(eb));
        check_val("overrun2", 32'(bus2.overrun), 32'(eo));
        check_val("overrun3", 32'(bus3.overrun), 32'(eo));
    endtask

    task automatic check_data();
        check_val("data2", 32'(bus2.data), last2);
        check_val("data3", 32'(bus3.data), last3);
    endtask

    // One mix starting at the current idle cycle; inputs are scrambled after every edge to
    // prove the snapshot. tick_at in 1..CH+1 injects a stray tick before that edge.
    task automatic run_mix(input logic [CH*VB-1:0] vol, input logic [CH*GB-1:0] gain,
                           input logic m, input int tick_at);
        int e2;
        int e3;
        e2 = model_mix(vol, gain, m, 2);
        e3 = model_mix(vol, gain, m, 3);
        tb_vol = vol;
        tb_gain = gain;
        tb_mute = m;
        tb_tick = 1'b1;
        @(posedge clk);
        #1;
        tb_tick = 1'b0;
        tb_vol = CH*VB'($urandom);
        tb_gain = CH*GB'($urandom);
        tb_mute = 1'($urandom);
        check_ctrl(1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= CH + 1; k++) begin
            tb_tick = (k == tick_at);
            @(posedge clk);
            #1;
            tb_tick = 1'b0;
            tb_vol = CH*VB'($urandom);
            tb_gain = CH*GB'($urandom);
            tb_mute = 1'($urandom);
            if (k == CH + 1) begin
                last2 = e2;
                last3 = e3;
            end
            check_ctrl(k == CH + 1, k <= CH, k == tick_at);
            check_data();
        end
        tb_mute = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
        check_ctrl(1'b0, 1'b0, 1'b0);
        check_data();
    endtask

    initial begin
        logic [CH*VB-1:0] v;
        logic [CH*GB-1:0] g;
        int ta;
        n_checks = 0;
        n_fail = 0;
        last2 = 0;
        last3 = 0;
        tb_tick = 1'b0;
        tb_vol = '0;
        tb_gain = '0;
        tb_mute = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_ctrl(1'b0, 1'b0, 1'b0);
        check_data();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) idle_cycle();

        // Directed corners, issued back to back.
        run_mix(16'h0000, 16'hFFFF, 1'b0, 0);
        run_mix(16'hFFFF, 16'hFFFF, 1'b0, 0);
        run_mix(16'hF0F0, 16'hFFFF, 1'b0, 0);
        run_mix(16'h0008, 16'hFFFF, 1'b0, 0);
        run_mix(16'hFFFF, 16'hFFFF, 1'b1, 0);
        idle_cycle();

        // Stray ticks during accumulate and during the finish cycle.
        run_mix(16'h1234, 16'hFEDC, 1'b0, 2);
        idle_cycle();
        run_mix(16'hFFFF, 16'hFFFF, 1'b0, CH + 1);
        idle_cycle();
        idle_cycle();

        // Asynchronous reset mid-clock while holding a non-zero sample.
        #2;
        reset_n = 1'b0;
        #1;
        last2 = 0;
        last3 = 0;
        check_ctrl(1'b0, 1'b0, 1'b0);
        check_data();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) idle_cycle();

        // Reset during a mix aborts it with no valid pulse.
        run_mix(16'hFFFF, 16'h1111, 1'b0, 0);
        tb_vol = 16'hFFFF;
        tb_gain = 16'hFFFF;
        tb_tick = 1'b1;
        @(posedge clk);
        #1;
        tb_tick = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        last2 = 0;
        last3 = 0;
        check_ctrl(1'b0, 1'b0, 1'b0);
        check_data();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (6) idle_cycle();
        run_mix(16'h0008, 16'hFFFF, 1'b0, 0);

        // Randomized mixes with occasional stray ticks and idle gaps.
        for (int n = 0; n < 30; n++) begin
            v = CH*VB'($urandom);
            g = CH*GB'($urandom);
            ta = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, CH + 1)) : 0;
            run_mix(v, g, $urandom_range(0, 7) == 0, ta);
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end
        idle_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
